// File: rtl/ov7670_capture.sv
// ov7670_capture
//   Samples the OV7670 byte stream (VSYNC/HREF/D) on PCLK, assembles 2-byte
//   pixels, keeps one pixel in H_DECIM per line and one line in V_DECIM per
//   frame, and writes one 8-bit word per kept pixel into the frame buffer.
//
//   Build option: define CAP_RGB332_EN to pack an RGB565 pair {b0,b1} into
//   RGB332 ({b0[7:5], b0[2:0], b1[4:3]}). Left undefined, the word written
//   is the first byte of each pair (luma in YUYV order).
//
// Ports
//   clk        in   camera PCLK, all logic on its rising edge
//   rst_n      in   asynchronous active-low reset
//   cap_en     in   capture enable, looked at only when a frame starts
//   cam_vsync  in   VSYNC, high between frames
//   cam_href   in   HREF, high while line bytes are valid
//   cam_d      in   [7:0] pixel byte
//   wea        out  frame buffer write strobe, one clk per kept pixel
//   addra      out  [14:0] write address, linear from 0 each frame
//   din        out  [7:0] pixel word
//   frame_done out  one-clk pulse at the end of a captured frame
//   overflow   out  sticky per frame: a kept pixel fell beyond FB_DEPTH
//   busy       out  high while capturing a frame
module ov7670_capture #(
  parameter int H_DECIM  = 10,
  parameter int V_DECIM  = 10,
  parameter int FB_DEPTH = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cap_en,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_d,
  output logic        wea,
  output logic [14:0] addra,
  output logic [7:0]  din,
  output logic        frame_done,
  output logic        overflow,
  output logic        busy
);

  localparam int HW = (H_DECIM > 1) ? $clog2(H_DECIM) : 1;
  localparam int VW = (V_DECIM > 1) ? $clog2(V_DECIM) : 1;
  localparam logic [15:0] DEPTH_W = 16'(FB_DEPTH);

  typedef enum logic [1:0] {SYNC, ARMED, CAPTURE} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            w_frame_end;

  logic            r_v, r_h, r_v_d, r_h_d;
  logic [7:0]      r_d, r_b0;
  logic            r_phase;
  logic [HW-1:0]   r_h_cnt;
  logic [VW-1:0]   r_v_cnt;
  logic            r_wea, r_frame_done, r_overflow;
  logic [14:0]     r_addra;
  logic [7:0]      r_din;

  logic            w_v_rise, w_v_fall, w_cap_start, w_active, w_keep, w_addr_ok;
  logic [HW-1:0]   w_h_cnt_next;
  logic [VW-1:0]   w_v_cnt_next;
  logic [7:0]      w_pix;

  assign w_v_rise    = r_v & ~r_v_d;
  assign w_v_fall    = ~r_v & r_v_d;
  assign w_cap_start = (r_state == ARMED) & w_v_fall & cap_en;
  // The clk that sees the closing VSYNC edge must not finish a pending pixel.
  assign w_active    = (r_state == CAPTURE) & ~w_v_rise;
  assign w_keep      = (r_h_cnt == '0) & (r_v_cnt == '0);
  assign w_addr_ok   = ({1'b0, r_addra} < DEPTH_W);

  assign w_h_cnt_next = (r_h_cnt == HW'(H_DECIM - 1)) ? '0 : r_h_cnt + HW'(1);
  assign w_v_cnt_next = (r_v_cnt == VW'(V_DECIM - 1)) ? '0 : r_v_cnt + VW'(1);

`ifdef CAP_RGB332_EN
  // r_d holds the second byte of the pair on the completing clk.
  assign w_pix = {r_b0[7:5], r_b0[2:0], r_d[4:3]};
`else
  assign w_pix = r_b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SYNC;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_frame_end  = 1'b0;
    case (r_state)
      SYNC:    if (r_v) w_state_next = ARMED;
      ARMED:   if (w_cap_start) w_state_next = CAPTURE;
      CAPTURE: begin
        if (w_v_rise) begin
          w_state_next = ARMED;
          w_frame_end  = 1'b1;
        end
      end
      default: w_state_next = SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v          <= 1'b0;
      r_h          <= 1'b0;
      r_d          <= 8'd0;
      r_v_d        <= 1'b0;
      r_h_d        <= 1'b0;
      r_b0         <= 8'd0;
      r_phase      <= 1'b0;
      r_h_cnt      <= '0;
      r_v_cnt      <= '0;
      r_wea        <= 1'b0;
      r_addra      <= 15'd0;
      r_din        <= 8'd0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_v          <= cam_vsync;
      r_h          <= cam_href;
      r_d          <= cam_d;
      r_v_d        <= r_v;
      r_h_d        <= r_h;
      r_wea        <= 1'b0;
      r_frame_done <= w_frame_end;
      // addra keeps the written address during wea and moves on afterwards;
      // writes only happen below FB_DEPTH, so it saturates at FB_DEPTH.
      if (r_wea) begin
        r_addra <= r_addra + 15'd1;
      end
      if (w_cap_start) begin
        r_addra    <= 15'd0;
        r_overflow <= 1'b0;
        r_phase    <= 1'b0;
        r_h_cnt    <= '0;
        r_v_cnt    <= '0;
      end else if (w_active) begin
        if (r_h) begin
          r_phase <= ~r_phase;
          if (!r_phase) begin
            r_b0 <= r_d;
          end else begin
            r_h_cnt <= w_h_cnt_next;
            if (w_keep) begin
              if (w_addr_ok) begin
                r_wea <= 1'b1;
                r_din <= w_pix;
              end else begin
                r_overflow <= 1'b1;
              end
            end
          end
        end else if (r_h_d) begin
          // End of line: an odd trailing byte is dropped here.
          r_phase <= 1'b0;
          r_h_cnt <= '0;
          r_v_cnt <= w_v_cnt_next;
        end
      end
    end
  end

  assign wea        = r_wea;
  assign addra      = r_addra;
  assign din        = r_din;
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;
  assign busy       = (r_state == CAPTURE);

endmodule
